// File: rtl/led_pkg.sv
// Shared types and widths for the LED row driver.
package led_pkg;

    localparam int unsigned ROW_ADDR_W = 5;
    localparam int unsigned ROW_NUM_W  = 6;
    localparam int unsigned BRIGHT_W   = 8;
    localparam int unsigned ON_CNT_W   = 16;
    localparam int unsigned OVR_W      = 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_BLANK,
        S_ADDR,
        S_SETTLE,
        S_ON
    } state_t;

    // On-time counter load value; the product deliberately wraps at 16 bits.
    function automatic logic [ON_CNT_W-1:0] on_load(input logic [BRIGHT_W-1:0] bright,
                                                    input int unsigned unit);
        return ON_CNT_W'(ON_CNT_W'(bright) * ON_CNT_W'(unit)) - ON_CNT_W'(1);
    endfunction

endpackage

// File: rtl/pulse_sync.sv
// Two-flop synchronizer plus rising-edge detect. A level already high when
// reset is released is ignored until it has been seen low once.
module pulse_sync (
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    output logic pulse
);

    logic       r_meta;
    logic       r_sync;
    logic       r_prev;
    logic [1:0] r_prime;
    logic       r_armed;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_meta  <= 1'b0;
            r_sync  <= 1'b0;
            r_prev  <= 1'b0;
            r_prime <= 2'b00;
            r_armed <= 1'b0;
        end else begin
            r_meta  <= async_in;
            r_sync  <= r_meta;
            r_prev  <= r_sync;
            // r_prime[1] marks that r_sync holds a real post-reset sample
            r_prime <= {r_prime[0], 1'b1};
            r_armed <= r_armed | (r_prime[1] & ~r_sync);
        end
    end

    assign pulse = r_sync & ~r_prev & r_armed;

endmodule

// File: rtl/led_row_driver.sv
// HUB75-style row sequencer: blank, switch address, settle, then light the row.
// Optional overrun counter enabled by defining LED_ROW_OVERRUN_CNT_EN.
module led_row_driver
    import led_pkg::*;
#(
    parameter int unsigned BLANK_CYCLES  = 4,
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter int unsigned ON_UNIT       = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  led_lat,
    input  logic [ROW_NUM_W-1:0]  row_num,
    input  logic [BRIGHT_W-1:0]   brightness,
    output logic [ROW_ADDR_W-1:0] row_addr,
    output logic                  led_oe,
    output logic                  busy
`ifdef LED_ROW_OVERRUN_CNT_EN
    ,
    output logic [OVR_W-1:0]      overrun_cnt
`endif
);

    localparam logic [ON_CNT_W-1:0] BLANK_LOAD  = ON_CNT_W'(BLANK_CYCLES - 1);
    localparam logic [ON_CNT_W-1:0] SETTLE_LOAD = ON_CNT_W'(SETTLE_CYCLES - 1);

    if (ON_UNIT * 255 > 65535) begin : g_bad_on_unit
        $error("led_row_driver: ON_UNIT*255 exceeds the 16-bit on-time counter");
    end
    if (BLANK_CYCLES < 1 || SETTLE_CYCLES < 1) begin : g_bad_cycles
        $error("led_row_driver: BLANK_CYCLES and SETTLE_CYCLES must be at least 1");
    end

    state_t                r_state;
    logic [ON_CNT_W-1:0]   r_cnt;
    logic [ROW_ADDR_W-1:0] r_row_cap;
    logic [ROW_ADDR_W-1:0] r_row_addr;
    logic                  r_led_oe;
    logic                  r_busy;
    logic                  w_lat_pulse;
    logic                  w_unused_row_msb;

    assign w_unused_row_msb = row_num[ROW_NUM_W-1];

    pulse_sync u_lat_sync (
        .clk      (clk),
        .rst      (rst),
        .async_in (led_lat),
        .pulse    (w_lat_pulse)
    );

    // Settle count covers the ADDR cycle too, so led_oe falls SETTLE_CYCLES
    // after row_addr moves.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_row_cap  <= '0;
            r_row_addr <= '0;
            r_led_oe   <= 1'b1;
            r_busy     <= 1'b0;
        end else begin
            if (w_lat_pulse) begin
                r_row_cap <= row_num[ROW_ADDR_W-1:0];
                r_state   <= S_BLANK;
                r_cnt     <= BLANK_LOAD;
                r_led_oe  <= 1'b1;
                r_busy    <= 1'b1;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        r_led_oe <= 1'b1;
                        r_busy   <= 1'b0;
                    end
                    S_BLANK: begin
                        if (r_cnt == '0) begin
                            r_state    <= S_ADDR;
                            r_row_addr <= r_row_cap;
                            r_cnt      <= SETTLE_LOAD;
                        end else begin
                            r_cnt <= r_cnt - ON_CNT_W'(1);
                        end
                    end
                    S_ADDR: begin
                        r_state <= S_SETTLE;
                        if (r_cnt != '0) begin
                            r_cnt <= r_cnt - ON_CNT_W'(1);
                        end
                    end
                    S_SETTLE: begin
                        if (r_cnt != '0) begin
                            r_cnt <= r_cnt - ON_CNT_W'(1);
                        end else if (brightness == '0) begin
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                        end else begin
                            r_state  <= S_ON;
                            r_cnt    <= on_load(brightness, ON_UNIT);
                            r_led_oe <= 1'b0;
                        end
                    end
                    S_ON: begin
                        if (r_cnt == '0) begin
                            r_state  <= S_IDLE;
                            r_led_oe <= 1'b1;
                            r_busy   <= 1'b0;
                        end else begin
                            r_cnt <= r_cnt - ON_CNT_W'(1);
                        end
                    end
                    default: begin
                        r_state  <= S_IDLE;
                        r_led_oe <= 1'b1;
                        r_busy   <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign row_addr = r_row_addr;
    assign led_oe   = r_led_oe;
    assign busy     = r_busy;

`ifdef LED_ROW_OVERRUN_CNT_EN
    logic [OVR_W-1:0] r_overrun_cnt;

    // Latches arriving before the previous row finished, saturating.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_overrun_cnt <= '0;
        end else if (w_lat_pulse && r_state != S_IDLE && r_overrun_cnt != '1) begin
            r_overrun_cnt <= r_overrun_cnt + OVR_W'(1);
        end
    end

    assign overrun_cnt = r_overrun_cnt;
`endif

endmodule

// File: tb/tb_led_row_driver.sv
// Directed bench for led_row_driver with default parameters.
module tb_led_row_driver;

    logic       clk;
    logic       rst;
    logic       led_lat;
    logic [5:0] row_num;
    logic [7:0] brightness;
    logic [4:0] row_addr;
    logic       led_oe;
    logic       busy;
`ifdef LED_ROW_OVERRUN_CNT_EN
    logic [7:0] overrun_cnt;
`endif

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;
    int n_low;
    int viol    = 0;
    logic       mon_en = 1'b0;
    logic [4:0] mon_prev_row = '0;

    led_row_driver dut (
        .clk        (clk),
        .rst        (rst),
        .led_lat    (led_lat),
        .row_num    (row_num),
        .brightness (brightness),
        .row_addr   (row_addr),
        .led_oe     (led_oe),
        .busy       (busy)
`ifdef LED_ROW_OVERRUN_CNT_EN
        ,
        .overrun_cnt(overrun_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // row_addr must hold steady whenever the panel is lit
    always @(negedge clk) begin
        if (mon_en && !led_oe && row_addr !== mon_prev_row) viol <= viol + 1;
        mon_prev_row <= row_addr;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst        = 1'b1;
        led_lat    = 1'b0;
        row_num    = '0;
        brightness = '0;
        #3;
        check("reset_oe",   32'(led_oe),   32'd1);
        check("reset_row",  32'(row_addr), 32'd0);
        check("reset_busy", 32'(busy),     32'd0);
        tick(2);
        rst = 1'b0;
        tick(6);

        // Basic row: brightness 1, row 5
        brightness = 8'd1;
        row_num    = 6'd5;
        led_lat    = 1'b1;
        tick(3);
        check("busy_in_blank", 32'(busy), 32'd1);
        tick(3);
        led_lat = 1'b0;
        check("row_before_addr", 32'(row_addr), 32'd0);
        tick(1);
        check("row_at_edge7", 32'(row_addr), 32'd5);
        check("oe_at_addr",   32'(led_oe),   32'd1);
        tick(1);
        check("oe_settle",    32'(led_oe),   32'd1);
        tick(1);
        check("oe_falls",     32'(led_oe),   32'd0);
        n_low = 0;
        while (led_oe == 1'b0 && n_low < 100) begin
            n_low++;
            tick(1);
        end
        check("on_len_b1",    32'(n_low), 32'd16);
        check("idle_after_on", 32'(busy), 32'd0);

        // Brightness 0: address moves, panel stays dark
        tick(2);
        brightness = 8'd0;
        row_num    = 6'd7;
        led_lat    = 1'b1;
        tick(4);
        led_lat = 1'b0;
        tick(3);
        check("dark_row",   32'(row_addr), 32'd7);
        tick(1);
        check("dark_busy8", 32'(busy),     32'd1);
        check("dark_oe8",   32'(led_oe),   32'd1);
        tick(1);
        check("dark_busy9", 32'(busy),     32'd0);
        tick(5);
        check("dark_oe_later", 32'(led_oe), 32'd1);

        // Full brightness, early abort 100 cycles into ON
        tick(2);
        brightness = 8'd255;
        row_num    = 6'd2;
        led_lat    = 1'b1;
        tick(4);
        led_lat = 1'b0;
        tick(5);
        check("b255_on",  32'(led_oe),   32'd0);
        check("b255_row", 32'(row_addr), 32'd2);
        tick(98);
        row_num = 6'd9;
        led_lat = 1'b1;
        tick(2);
        check("abort_still_on", 32'(led_oe), 32'd0);
        tick(1);
        check("abort_oe_high",  32'(led_oe), 32'd1);
        check("abort_busy",     32'(busy),   32'd1);
        led_lat = 1'b0;
        tick(3);
        check("abort_row_held", 32'(row_addr), 32'd2);
        tick(1);
        check("abort_row_new",  32'(row_addr), 32'd9);
        tick(2);
        check("abort_relit",    32'(led_oe),   32'd0);
`ifdef LED_ROW_OVERRUN_CNT_EN
        check("ovr_one", 32'(overrun_cnt), 32'd1);
`endif

        // Asynchronous reset mid-ON, latch held high across release
        #2;
        rst = 1'b1;
        #1;
        check("arst_oe",   32'(led_oe),   32'd1);
        check("arst_row",  32'(row_addr), 32'd0);
        check("arst_busy", 32'(busy),     32'd0);
        led_lat = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(10);
        check("held_lat_busy", 32'(busy),     32'd0);
        check("held_lat_row",  32'(row_addr), 32'd0);
        led_lat = 1'b0;
        tick(5);

        // row_num[5] ignored
        brightness = 8'd1;
        row_num    = 6'h3F;
        led_lat    = 1'b1;
        tick(4);
        led_lat = 1'b0;
        tick(3);
        check("row_3f", 32'(row_addr), 32'h1F);
`ifdef LED_ROW_OVERRUN_CNT_EN
        check("ovr_zero_after_idle_latch", 32'(overrun_cnt), 32'd0);
`endif

        // 300 back-to-back latches while busy
        for (int i = 0; i < 300; i++) begin
            led_lat = 1'b1;
            tick(2);
            led_lat = 1'b0;
            tick(2);
        end
        tick(1);
        check("train_busy", 32'(busy),   32'd1);
        check("train_oe",   32'(led_oe), 32'd1);
`ifdef LED_ROW_OVERRUN_CNT_EN
        check("ovr_saturate", 32'(overrun_cnt), 32'd255);
`endif
        tick(40);
        check("train_idle", 32'(busy), 32'd0);

        // Random latches with row_addr stability monitor
        mon_en = 1'b1;
        for (int i = 0; i < 25; i++) begin
            row_num    = 6'($urandom_range(0, 63));
            brightness = 8'($urandom_range(0, 3));
            led_lat    = 1'b1;
            tick(2);
            led_lat = 1'b0;
            tick(int'($urandom_range(3, 70)));
        end
        tick(80);
        mon_en = 1'b0;
        check("row_stable_while_lit", 32'(viol), 32'd0);
        check("random_end_idle",      32'(busy), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/led_row_driver.md
LED_ROW_DRIVER -- requirements
Module: led_row_driver

Interface
REQ-001 Parameter BLANK_CYCLES, default 4: cycles led_oe is held high before the row address changes.
REQ-002 Parameter SETTLE_CYCLES, default 2: cycles after the address change before led_oe may go low.
REQ-003 Parameter ON_UNIT, default 16: clk cycles of on-time per brightness LSB.
REQ-004 Port clk, input, 1: single system clock; all logic on its rising edge.
REQ-005 Port rst, input, 1: asynchronous, active-high reset.
REQ-006 Port led_lat, input, 1: latch strobe from the serial mask stage; asynchronous to clk, high for at least one i2s_clk period.
REQ-007 Port row_num, input, 6: row index from the mask stage; stable from the rising edge of led_lat until the next latch.
REQ-008 Port brightness, input, 8: global on-time scale; 0 = display dark.
REQ-009 Port row_addr, output, 5: panel row select lines A..E.
REQ-010 Port led_oe, output, 1: panel output enable, active-low.
REQ-011 Port busy, output, 1: high in any state other than IDLE.

Function
REQ-012 led_lat shall pass through a 2-flop synchronizer and rising-edge detect, producing a one-cycle lat_pulse 3 clk cycles after the led_lat rise.
REQ-013 States: IDLE, BLANK, ADDR, SETTLE, ON.
REQ-014 IDLE: led_oe=1, row_addr held; on lat_pulse go to BLANK, loading the counter with BLANK_CYCLES-1.
REQ-015 BLANK: led_oe=1; the counter decrements each cycle; at 0 go to ADDR.
REQ-016 ADDR (one cycle): row_addr is registered from row_num[4:0], captured at the lat_pulse cycle; counter loads SETTLE_CYCLES-1; go to SETTLE.
REQ-017 SETTLE: led_oe=1; at counter 0, if brightness is 0 go to IDLE, else go to ON with a 16-bit counter loaded with brightness*ON_UNIT-1.
REQ-018 The brightness value shall be sampled once, on entry to ON; later changes do not affect the current row.
REQ-019 ON: led_oe=0; at counter 0 set led_oe=1 and go to IDLE.
REQ-020 A lat_pulse in ON shall force led_oe=1 on the next edge and go to BLANK with the new row captured (early abort).
REQ-021 A lat_pulse in BLANK, ADDR or SETTLE shall restart BLANK and replace the captured row; row_addr shall never change while led_oe=0.
REQ-022 The brightness*ON_UNIT product shall be computed at 16 bits; parameters with ON_UNIT*255 > 65535 are illegal (elaboration-time assertion).
REQ-023 row_num[5] is ignored.
REQ-024 busy = (state != IDLE), registered along with the state.

Reset
REQ-025 Asserting rst shall force IDLE, led_oe=1, row_addr=0, busy=0, all counters and synchronizer flops to 0, with no clock required.
REQ-026 Reset asserted during ON shall drive led_oe high immediately (asynchronously).
REQ-027 After rst deasserts, a led_lat already high shall not generate a lat_pulse; a fresh rising edge is required.

Configuration
REQ-028 Macro LED_ROW_OVERRUN_CNT_EN defined: add output overrun_cnt [7:0], reset to 0, incremented by 1 and saturating at 255 on each lat_pulse received in ON, BLANK, ADDR or SETTLE.
REQ-029 Macro LED_ROW_OVERRUN_CNT_EN undefined: the port and the counter are absent; all other behaviour is identical.

Structure
REQ-030 Shared package led_pkg holds the state enum, the ROW_ADDR_W=5 constant and the ON counter width of 16.
REQ-031 The synchronizer and edge detect shall be a separate sub-module, pulse_sync (inputs async_in, clk, rst; output pulse).

Verification
REQ-032 Defaults, brightness=1, led_lat pulse with row_num=5 -> led_oe low for exactly 16 cycles; row_addr=5 appears 3+4 cycles after the led_lat rise; led_oe falls 2 cycles after row_addr changes.
REQ-033 brightness=0, latch with row_num=7 -> row_addr=7, led_oe never low, busy drops after SETTLE.
REQ-034 brightness=255, second latch 100 cycles into ON with row_num=9 -> led_oe high on the next edge; row_addr=9 only after 4 blank cycles; overrun_cnt=1 when the macro is defined.
REQ-035 rst asserted mid-ON -> led_oe=1, row_addr=0 without a clock edge; led_lat held high across the rst release -> no activity.
REQ-036 row_num=6'h3F -> row_addr=5'h1F; 300 back-to-back overrun latches -> overrun_cnt saturates at 255.
REQ-037 Random latches/brightness, continuous assertion: row_addr stable whenever led_oe=0.
